// File: rtl/pmp_pkg.sv
// Shared PMP constants and the cfg byte layout used by the CSR register file.
package pmp_pkg;

  localparam logic [11:0] PMPCFG0     = 12'h3A0;
  localparam logic [11:0] PMPADDR0    = 12'h3B0;
  localparam int          PMPADDR_NUM = 64;
  localparam logic [1:0]  M_MODE      = 2'b11;

  localparam int CFG_W = 1;
  localparam int CFG_R = 0;

  typedef enum logic [1:0] {
    A_OFF   = 2'd0,
    A_TOR   = 2'd1,
    A_NA4   = 2'd2,
    A_NAPOT = 2'd3
  } pmp_a_e;

  // Bit order: L=7, reserved=6:5, A=4:3, X=2, W=1, R=0
  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    logic [1:0] a;
    logic       x;
    logic       w;
    logic       r;
  } pmp_cfg_t;

  // W=1 with R=0 is a reserved combination, so it collapses to no-write.
  function automatic pmp_cfg_t legalize_cfg(input logic [7:0] raw);
    logic [7:0] v;
    v      = raw;
    v[6:5] = 2'b00;
    if (!v[CFG_R]) v[CFG_W] = 1'b0;
    return pmp_cfg_t'(v);
  endfunction

endpackage

// File: rtl/pmp_entry_reg.sv
// One PMP entry: cfg byte plus address, with lock gating and WARL legalisation.
module pmp_entry_reg
  import pmp_pkg::*;
#(
  parameter int AW = 54
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cfg_we,
  input  logic [7:0]    cfg_wdata,
  input  logic          addr_we,
  input  logic [AW-1:0] addr_wdata,
  input  logic          next_l,
  input  logic [1:0]    next_a,
  output pmp_cfg_t      cfg,
  output logic [AW-1:0] addr,
  output logic          changed
);

  pmp_cfg_t cfg_legal;
  logic     cfg_ok;
  logic     addr_ok;

  assign cfg_legal = legalize_cfg(cfg_wdata);
  assign cfg_ok    = cfg_we & ~cfg.l;
  // A locked TOR entry above also freezes this entry's address (its lower bound).
  assign addr_ok   = addr_we & ~cfg.l & ~(next_l & (next_a == A_TOR));
  assign changed   = (cfg_ok & (cfg_legal != cfg)) | (addr_ok & (addr_wdata != addr));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg  <= '0;
      addr <= '0;
    end else begin
      if (cfg_ok)  cfg  <= cfg_legal;
      if (addr_ok) addr <= addr_wdata;
    end
  end

endmodule

// File: rtl/csr_pmp_regs.sv
// Machine-mode pmpcfg/pmpaddr CSR file: write decode, lock rules, reads and update pulse.
module csr_pmp_regs
  import pmp_pkg::*;
#(
  parameter  int PMP_ENTRIES = 16,
  parameter  int XLEN        = 64,
  parameter  int PA_BITS     = 56,
  localparam int NE          = (PMP_ENTRIES == 0) ? 1 : PMP_ENTRIES,
  localparam int AW          = PA_BITS - 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            StallW,
  input  logic            CSRMWriteM,
  input  logic [11:0]     CSRAdrM,
  input  logic [XLEN-1:0] CSRWriteValM,
  input  logic [1:0]      PrivilegeModeW,
  output logic [7:0]      PMPCFG_ARRAY_REGW  [NE],
  output logic [AW-1:0]   PMPADDR_ARRAY_REGW [NE],
  output logic [XLEN-1:0] CSRReadValM,
  output logic            IllegalPMPAccessM,
  output logic            PMPUpdatedM
);

  localparam int BPR = XLEN / 8;

  logic          is_cfg;
  logic          is_addr;
  logic          in_range;
  logic          commit;
  logic [3:0]    cfg_n;
  logic [5:0]    addr_i;
  int            cfg_base;

  pmp_cfg_t      cfg_q      [NE];
  logic [AW-1:0] addr_q     [NE];
  logic          cfg_we     [NE];
  logic [7:0]    cfg_wd     [NE];
  logic          addr_we    [NE];
  logic [AW-1:0] addr_wd;
  logic [NE-1:0] changed;

  assign is_cfg   = (CSRAdrM[11:4] == PMPCFG0[11:4]);
  assign is_addr  = (CSRAdrM >= PMPADDR0) && (CSRAdrM < (PMPADDR0 + 12'(PMPADDR_NUM)));
  assign in_range = is_cfg | is_addr;
  assign cfg_n    = CSRAdrM[3:0];
  assign addr_i   = 6'(CSRAdrM - PMPADDR0);
  assign cfg_base = 4 * int'(cfg_n);
  assign addr_wd  = AW'(CSRWriteValM);

  // Odd pmpcfg indices do not exist when each register carries eight bytes.
  assign IllegalPMPAccessM = in_range &
                             ((PrivilegeModeW != M_MODE) | ((XLEN == 64) & is_cfg & CSRAdrM[0]));
  assign commit = CSRMWriteM & ~StallW & ~IllegalPMPAccessM & in_range;

  always_comb begin
    for (int i = 0; i < NE; i++) begin
      cfg_we[i]  = 1'b0;
      cfg_wd[i]  = 8'h00;
      addr_we[i] = 1'b0;
      if ((PMP_ENTRIES > 0) && commit) begin
        if (is_cfg && (i >= cfg_base) && (i < cfg_base + BPR)) begin
          cfg_we[i] = 1'b1;
          cfg_wd[i] = 8'(CSRWriteValM >> (8 * (i - cfg_base)));
        end
        if (is_addr && (int'(addr_i) == i)) addr_we[i] = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NE; i++) begin : g_entry
    if (PMP_ENTRIES > 0) begin : g_impl
      logic       next_l;
      logic [1:0] next_a;
      if (i < PMP_ENTRIES - 1) begin : g_next
        assign next_l = cfg_q[i+1].l;
        assign next_a = cfg_q[i+1].a;
      end else begin : g_last
        assign next_l = 1'b0;
        assign next_a = A_OFF;
      end

      pmp_entry_reg #(.AW(AW)) u_entry (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_we     (cfg_we[i]),
        .cfg_wdata  (cfg_wd[i]),
        .addr_we    (addr_we[i]),
        .addr_wdata (addr_wd),
        .next_l     (next_l),
        .next_a     (next_a),
        .cfg        (cfg_q[i]),
        .addr       (addr_q[i]),
        .changed    (changed[i])
      );
    end else begin : g_none
      assign cfg_q[i]   = '0;
      assign addr_q[i]  = '0;
      assign changed[i] = 1'b0;
    end

    assign PMPCFG_ARRAY_REGW[i]  = cfg_q[i];
    assign PMPADDR_ARRAY_REGW[i] = addr_q[i];
  end

  always_comb begin
    CSRReadValM = '0;
    if (PMP_ENTRIES > 0) begin
      for (int i = 0; i < NE; i++) begin
        if (is_cfg && (i >= cfg_base) && (i < cfg_base + BPR))
          CSRReadValM = CSRReadValM | (XLEN'(cfg_q[i]) << (8 * (i - cfg_base)));
        if (is_addr && (int'(addr_i) == i))
          CSRReadValM = XLEN'(addr_q[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) PMPUpdatedM <= 1'b0;
    else          PMPUpdatedM <= |changed;
  end

endmodule

// File: tb/tb_csr_pmp_regs.sv
// Directed bench for csr_pmp_regs; a negedge monitor drains a queue of expected observations.
module tb_csr_pmp_regs;

  localparam int K_RD  = 0;
  localparam int K_CFG = 1;
  localparam int K_ADR = 2;
  localparam int K_ILL = 3;
  localparam int K_UPD = 4;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [63:0] exp;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        StallW;
  logic        CSRMWriteM;
  logic [11:0] CSRAdrM;
  logic [63:0] CSRWriteValM;
  logic [1:0]  PrivilegeModeW;
  logic [7:0]  cfg_arr  [16];
  logic [53:0] addr_arr [16];
  logic [63:0] CSRReadValM;
  logic        IllegalPMPAccessM;
  logic        PMPUpdatedM;

  sb_entry_t sb[$];
  int checks   = 0;
  int failures = 0;

  csr_pmp_regs dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .StallW             (StallW),
    .CSRMWriteM         (CSRMWriteM),
    .CSRAdrM            (CSRAdrM),
    .CSRWriteValM       (CSRWriteValM),
    .PrivilegeModeW     (PrivilegeModeW),
    .PMPCFG_ARRAY_REGW  (cfg_arr),
    .PMPADDR_ARRAY_REGW (addr_arr),
    .CSRReadValM        (CSRReadValM),
    .IllegalPMPAccessM  (IllegalPMPAccessM),
    .PMPUpdatedM        (PMPUpdatedM)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] observe(input int kind, input int idx);
    case (kind)
      K_RD:    return CSRReadValM;
      K_CFG:   return 64'(cfg_arr[idx]);
      K_ADR:   return 64'(addr_arr[idx]);
      K_ILL:   return 64'(IllegalPMPAccessM);
      default: return 64'(PMPUpdatedM);
    endcase
  endfunction

  always @(negedge clk) begin
    sb_entry_t   e;
    logic [63:0] act;
    while (sb.size() != 0) begin
      e   = sb.pop_front();
      act = observe(e.kind, e.idx);
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_val(input string name, input int kind, input int idx, input logic [63:0] exp);
    sb.push_back('{name, kind, idx, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [63:0] v);
    CSRAdrM      = a;
    CSRWriteValM = v;
    CSRMWriteM   = 1'b1;
    tick();
    CSRMWriteM   = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    StallW         = 1'b0;
    CSRMWriteM     = 1'b0;
    CSRAdrM        = 12'h000;
    CSRWriteValM   = '0;
    PrivilegeModeW = 2'b11;
    tick();
    tick();
    reset_n = 1'b1;
    expect_val("rst_cfg0", K_CFG, 0, 64'h0);
    expect_val("rst_addr0", K_ADR, 0, 64'h0);
    expect_val("rst_upd", K_UPD, 0, 64'h0);
    tick();

    csr_write(12'h3A0, 64'h8F0B);
    expect_val("cfg0_wr", K_CFG, 0, 64'h0B);
    expect_val("cfg1_wr", K_CFG, 1, 64'h8F);
    expect_val("cfg_rd", K_RD, 0, 64'h8F0B);
    expect_val("upd_pulse", K_UPD, 0, 64'h1);
    tick();
    expect_val("upd_drop", K_UPD, 0, 64'h0);
    tick();

    csr_write(12'h3A0, 64'h0);
    expect_val("cfg0_clr", K_CFG, 0, 64'h00);
    expect_val("cfg1_locked", K_CFG, 1, 64'h8F);
    tick();

    csr_write(12'h3A0, 64'h8800_0000);
    expect_val("cfg3_tor", K_CFG, 3, 64'h88);
    tick();
    csr_write(12'h3B2, 64'h1234);
    expect_val("addr2_torlock", K_ADR, 2, 64'h0);
    expect_val("upd_torlock", K_UPD, 0, 64'h0);
    tick();
    csr_write(12'h3B3, 64'h55);
    expect_val("addr3_locked", K_ADR, 3, 64'h0);
    tick();
    csr_write(12'h3A2, 64'h01);
    expect_val("cfg8_wr", K_CFG, 8, 64'h01);
    expect_val("upd_cfg8", K_UPD, 0, 64'h1);
    tick();

    csr_write(12'h3A2, 64'h03);
    reset_n = 1'b0;
    expect_val("arst_cfg1", K_CFG, 1, 64'h0);
    expect_val("arst_cfg3", K_CFG, 3, 64'h0);
    expect_val("arst_cfg8", K_CFG, 8, 64'h0);
    expect_val("arst_upd", K_UPD, 0, 64'h0);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    tick();

    csr_write(12'h3A0, 64'h8000_0000);
    expect_val("cfg3_off", K_CFG, 3, 64'h80);
    tick();
    csr_write(12'h3B2, 64'h1234);
    expect_val("addr2_offlock", K_ADR, 2, 64'h1234);
    expect_val("upd_addr2", K_UPD, 0, 64'h1);
    tick();
    expect_val("upd_addr2_end", K_UPD, 0, 64'h0);
    tick();

    csr_write(12'h3A0, 64'h62);
    expect_val("warl_62", K_CFG, 0, 64'h00);
    expect_val("upd_nochange", K_UPD, 0, 64'h0);
    tick();
    csr_write(12'h3A0, 64'h07);
    expect_val("warl_07", K_CFG, 0, 64'h07);
    expect_val("cfg_rd2", K_RD, 0, 64'h8000_0007);
    tick();

    PrivilegeModeW = 2'b01;
    CSRAdrM        = 12'h3B0;
    CSRWriteValM   = 64'hFF;
    CSRMWriteM     = 1'b1;
    expect_val("ill_smode", K_ILL, 0, 64'h1);
    tick();
    CSRMWriteM     = 1'b0;
    expect_val("ill_smode_addr0", K_ADR, 0, 64'h0);
    expect_val("ill_smode_upd", K_UPD, 0, 64'h0);
    PrivilegeModeW = 2'b11;
    tick();
    CSRAdrM      = 12'h3A1;
    CSRWriteValM = 64'h0;
    CSRMWriteM   = 1'b1;
    expect_val("ill_odd_cfg", K_ILL, 0, 64'h1);
    tick();
    CSRMWriteM = 1'b0;
    expect_val("odd_cfg0", K_CFG, 0, 64'h07);
    expect_val("odd_upd", K_UPD, 0, 64'h0);
    CSRAdrM = 12'h3A2;
    expect_val("legal_cfg2", K_ILL, 0, 64'h0);
    tick();

    CSRAdrM      = 12'h3C4;
    CSRWriteValM = 64'hDEAD;
    CSRMWriteM   = 1'b1;
    expect_val("legal_addr20", K_ILL, 0, 64'h0);
    tick();
    CSRMWriteM = 1'b0;
    expect_val("rd_addr20", K_RD, 0, 64'h0);
    expect_val("upd_addr20", K_UPD, 0, 64'h0);
    tick();
    CSRAdrM = 12'h300;
    expect_val("rd_nonpmp", K_RD, 0, 64'h0);
    expect_val("ill_nonpmp", K_ILL, 0, 64'h0);
    tick();

    CSRAdrM      = 12'h3B5;
    CSRWriteValM = 64'hABC;
    CSRMWriteM   = 1'b1;
    StallW       = 1'b1;
    tick();
    tick();
    expect_val("stall_addr5", K_ADR, 5, 64'h0);
    expect_val("stall_upd", K_UPD, 0, 64'h0);
    StallW = 1'b0;
    expect_val("rd_commit_old", K_RD, 0, 64'h0);
    tick();
    CSRMWriteM = 1'b0;
    expect_val("rd_commit_new", K_RD, 0, 64'hABC);
    expect_val("addr5_new", K_ADR, 5, 64'hABC);
    expect_val("upd_addr5", K_UPD, 0, 64'h1);
    tick();

    for (int n = 0; n < 100 && sb.size() != 0; n++) tick();
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0 pending", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
